// File: rtl/gpr_multiport.sv
// gpr_multiport: general-purpose register file with two combinational read
// ports, two write ports (port 1 wins on address collision) and a per-register
// pending scoreboard with issue / writeback / flush and a live pending count.
// Optional feature: define GPR_MULTIPORT_BYPASS_EN to forward same-cycle write
// data onto the read ports.
module gpr_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] outa,
    output logic [DATA_W-1:0] outb,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              flush,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [ADDR_W:0]   r_pend_cnt;

    logic [DEPTH-1:0]  w_pend_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;

    // Next pending vector: flush clears everything and blocks the issue;
    // otherwise a writeback clears and an issue sets, the issue taking priority.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                w_pend_nxt[i] = 1'b0;
            end else if (iss && iss_rd == ADDR_W'(i)) begin
                w_pend_nxt[i] = 1'b1;
            end else if ((we0 && wa0 == ADDR_W'(i)) || (we1 && wa1 == ADDR_W'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end
            if (ZERO_REG != 0 && i == 0) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    // Pending count is the population of the next vector, so it can never wrap
    // and re-issuing an already pending register leaves it unchanged.
    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[i]};
        end
    end

    // Register array update; port 1 overrides port 0 on the same address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(ZERO_REG != 0 && i == 0)) begin
                    if (we1 && wa1 == ADDR_W'(i)) begin
                        r_regs[i] <= wd1;
                    end else if (we0 && wa0 == ADDR_W'(i)) begin
                        r_regs[i] <= wd0;
                    end
                end
            end
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

`ifdef GPR_MULTIPORT_BYPASS_EN
    // Read port A with forwarding of this cycle's write data.
    always_comb begin
        if (ZERO_REG != 0 && rs == '0)  outa = '0;
        else if (we1 && wa1 == rs)       outa = wd1;
        else if (we0 && wa0 == rs)       outa = wd0;
        else                             outa = r_regs[rs];
    end

    // Read port B with forwarding of this cycle's write data.
    always_comb begin
        if (ZERO_REG != 0 && rt == '0)  outb = '0;
        else if (we1 && wa1 == rt)       outb = wd1;
        else if (we0 && wa0 == rt)       outb = wd0;
        else                             outb = r_regs[rt];
    end
`else
    // Read port A returns the stored (pre-edge) contents.
    always_comb begin
        if (ZERO_REG != 0 && rs == '0)  outa = '0;
        else                             outa = r_regs[rs];
    end

    // Read port B returns the stored (pre-edge) contents.
    always_comb begin
        if (ZERO_REG != 0 && rt == '0)  outb = '0;
        else                             outb = r_regs[rt];
    end
`endif

    assign busy_a   = r_pend[rs];
    assign busy_b   = r_pend[rt];
    assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_gpr_multiport.sv
// Scoreboard bench for gpr_multiport: a driver issues one stimulus per cycle
// and queues the expected read/busy/count view; a monitor pops and compares
// just before the next rising edge.
module tb_gpr_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] rs = '0, rt = '0, wa0 = '0, wa1 = '0, iss_rd = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          we0 = 1'b0, we1 = 1'b0, iss = 1'b0, flush = 1'b0;
    logic [DW-1:0] outa, outb;
    logic          busy_a, busy_b;
    logic [AW:0]   pend_cnt;

    gpr_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .outa(outa), .outb(outb),
        .busy_a(busy_a), .busy_b(busy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss(iss), .iss_rd(iss_rd), .flush(flush), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          ba;
        logic          bb;
        int            cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // reference state: architectural register values and set of pending registers
    logic [DW-1:0] m_reg [DEPTH];
    bit            m_pend [DEPTH];

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef GPR_MULTIPORT_BYPASS_EN
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
`endif
        return m_reg[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        foreach (m_pend[i]) n += m_pend[i] ? 1 : 0;
        return n;
    endfunction

    task automatic m_clear();
        foreach (m_reg[i]) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic step(input logic a_rst,
                        input logic [AW-1:0] a_rs, input logic [AW-1:0] a_rt,
                        input logic a_we0, input logic [AW-1:0] a_wa0, input logic [DW-1:0] a_wd0,
                        input logic a_we1, input logic [AW-1:0] a_wa1, input logic [DW-1:0] a_wd1,
                        input logic a_iss, input logic [AW-1:0] a_ird, input logic a_flush);
        exp_t e;
        @(negedge clk);
        rst = a_rst; rs = a_rs; rt = a_rt;
        we0 = a_we0; wa0 = a_wa0; wd0 = a_wd0;
        we1 = a_we1; wa1 = a_wa1; wd1 = a_wd1;
        iss = a_iss; iss_rd = a_ird; flush = a_flush;
        if (a_rst) m_clear();
        e.a = m_read(a_rs);
        e.b = m_read(a_rt);
        e.ba = m_pend[a_rs];
        e.bb = m_pend[a_rt];
        e.cnt = m_count();
        exp_q.push_back(e);
        if (!a_rst) begin
            if (a_we0 && a_wa0 != 0) m_reg[a_wa0] = a_wd0;
            if (a_we1 && a_wa1 != 0) m_reg[a_wa1] = a_wd1;
            if (a_flush) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
            end else begin
                if (a_we0) m_pend[a_wa0] = 1'b0;
                if (a_we1) m_pend[a_wa1] = 1'b0;
                if (a_iss && a_ird != 0) m_pend[a_ird] = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic [AW-1:0] a_rs, input logic [AW-1:0] a_rt);
        step(0, a_rs, a_rt, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor: compare the DUT view against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (outa !== e.a) begin
                    failures++;
                    $display("FAIL outa rs=%0d got=%h exp=%h t=%0t", rs, outa, e.a, $time);
                end
                checks++;
                if (outb !== e.b) begin
                    failures++;
                    $display("FAIL outb rt=%0d got=%h exp=%h t=%0t", rt, outb, e.b, $time);
                end
                checks++;
                if (busy_a !== e.ba) begin
                    failures++;
                    $display("FAIL busy_a rs=%0d got=%b exp=%b t=%0t", rs, busy_a, e.ba, $time);
                end
                checks++;
                if (busy_b !== e.bb) begin
                    failures++;
                    $display("FAIL busy_b rt=%0d got=%b exp=%b t=%0t", rt, busy_b, e.bb, $time);
                end
                checks++;
                if (int'(pend_cnt) != e.cnt) begin
                    failures++;
                    $display("FAIL pend_cnt got=%0d exp=%0d t=%0t", pend_cnt, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        m_clear();
        // reset with a coincident write/issue that must be discarded
        step(1, 3, 31, 1, 3, 32'h12345678, 1, 31, 32'h9abcdef0, 1, 3, 0);
        step(1, 3, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 31);
        idle(3, 31);
        // dual-write collision on address 5: port 1 wins
        step(0, 5, 0, 1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 0);
        idle(5, 0);
        // register 0 is hardwired
        step(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0);
        idle(0, 5);
        // scoreboard: issue 4, issue 7, write+issue 4, write 7
        step(0, 4, 7, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        step(0, 4, 7, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        step(0, 4, 7, 1, 4, 32'h44444444, 0, 0, 0, 1, 4, 0);
        step(0, 4, 7, 0, 0, 0, 1, 7, 32'h77777777, 0, 0, 0);
        idle(4, 7);
        // re-issue of an already pending register
        step(0, 4, 7, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        idle(4, 9);
        // flush beats issue; writes still land
        step(0, 9, 4, 1, 9, 32'h99999999, 0, 0, 0, 1, 9, 1);
        idle(9, 4);
        // same-cycle read of a port 1 write
        step(0, 6, 6, 0, 0, 0, 1, 6, 32'hCAFEF00D, 0, 0, 0);
        idle(6, 6);
        // randomized traffic on a narrow address window for frequent collisions
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] lim;
            lim = (n < 300) ? AW'(7) : AW'(31);
            step((n == 450) ? 1'b1 : 1'b0,
                 AW'($urandom_range(0, lim)), AW'($urandom_range(0, lim)),
                 1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, lim)), $urandom(),
                 1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, lim)), $urandom(),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, lim)),
                 1'($urandom_range(0, 15) == 0));
        end
        idle(0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
